// File: rtl/ram_fake_latency_mem.sv
// Behavioural latency-injecting memory model with independent read/write channels.
// Define RAM_FAKE_RANDOM_STALL_EN to add 0-3 pseudo-random extra wait cycles per request.
module ram_fake_latency_mem #(
    parameter int          WORD_W        = 32,
    parameter int          DEPTH         = 64,
    parameter int          READ_LATENCY  = 2,
    parameter int          WRITE_LATENCY = 1,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                w_req,
    output logic                w_ready,
    input  logic [WORD_W-1:0]   w_addr,
    input  logic [WORD_W-1:0]   w_data_in,
    input  logic [WORD_W/8-1:0] w_strb,
    output logic                w_resp,
    output logic                w_err,
    input  logic                r_req,
    output logic                r_ready,
    input  logic [WORD_W-1:0]   r_addr,
    output logic [WORD_W-1:0]   r_data_out,
    output logic                r_resp,
    output logic                r_err
);

    localparam int STRB_W  = WORD_W / 8;
    localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int R_CNT_W = $clog2(READ_LATENCY + 4);
    localparam int W_CNT_W = $clog2(WRITE_LATENCY + 4);

    // Elaboration-time sanity: zero latency and an all-zero LFSR seed are unusable.
    if (READ_LATENCY < 1 || WRITE_LATENCY < 1) begin : g_bad_latency
        $error("ram_fake_latency_mem: latencies must be >= 1");
    end
    if (LFSR_SEED == 16'h0000) begin : g_bad_seed
        $error("ram_fake_latency_mem: LFSR_SEED must be non-zero");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t               w_state_reg, w_state_next;
    state_t               r_state_reg, r_state_next;
    logic [W_CNT_W-1:0]   w_cnt_reg, w_cnt_next;
    logic [R_CNT_W-1:0]   r_cnt_reg, r_cnt_next;
    logic                 w_err_reg, r_err_reg;
    logic [WORD_W-1:0]    r_hold_word;
    logic [1:0]           w_extra, r_extra;

    logic                 w_accept, r_accept;
    logic                 w_in_range, r_in_range;
    logic [IDX_W-1:0]     w_idx, r_idx;

    assign w_ready    = (w_state_reg == IDLE);
    assign r_ready    = (r_state_reg == IDLE);
    assign w_accept   = w_req && w_ready;
    assign r_accept   = r_req && r_ready;
    assign w_in_range = (w_addr < WORD_W'(DEPTH));
    assign r_in_range = (r_addr < WORD_W'(DEPTH));
    assign w_idx      = w_addr[IDX_W-1:0];
    assign r_idx      = r_addr[IDX_W-1:0];

`ifdef RAM_FAKE_RANDOM_STALL_EN
    logic [15:0] lfsr_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_reg <= LFSR_SEED;
        end else begin
            lfsr_reg <= {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
        end
    end

    assign r_extra = lfsr_reg[1:0];
    assign w_extra = lfsr_reg[3:2];
`else
    assign r_extra = 2'd0;
    assign w_extra = 2'd0;
`endif

    // One byte-wide array per lane: strobed writes touch only their own lane, and the
    // read snapshot is taken from the pre-write contents on a same-edge collision.
    for (genvar gi = 0; gi < STRB_W; gi++) begin : g_lane
        logic [7:0] lane_mem [DEPTH];
        logic [7:0] r_byte_reg;

        always_ff @(posedge clk) begin
            if (reset) begin
                for (int i = 0; i < DEPTH; i++) begin
                    lane_mem[i] <= 8'h00;
                end
                r_byte_reg <= 8'h00;
            end else begin
                if (w_accept && w_in_range && w_strb[gi]) begin
                    lane_mem[w_idx] <= w_data_in[8*gi +: 8];
                end
                if (r_accept) begin
                    r_byte_reg <= r_in_range ? lane_mem[r_idx] : 8'h00;
                end
            end
        end

        assign r_hold_word[8*gi +: 8] = r_byte_reg;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            w_state_reg <= IDLE;
            r_state_reg <= IDLE;
            w_cnt_reg   <= '0;
            r_cnt_reg   <= '0;
            w_err_reg   <= 1'b0;
            r_err_reg   <= 1'b0;
        end else begin
            w_state_reg <= w_state_next;
            r_state_reg <= r_state_next;
            w_cnt_reg   <= w_cnt_next;
            r_cnt_reg   <= r_cnt_next;
            if (w_accept) begin
                w_err_reg <= !w_in_range;
            end
            if (r_accept) begin
                r_err_reg <= !r_in_range;
            end
        end
    end

    always_comb begin
        w_state_next = w_state_reg;
        w_cnt_next   = w_cnt_reg;
        case (w_state_reg)
            IDLE: begin
                if (w_req) begin
                    w_cnt_next   = W_CNT_W'(WRITE_LATENCY - 1) + W_CNT_W'(w_extra);
                    w_state_next = (w_cnt_next == '0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                w_cnt_next = w_cnt_reg - W_CNT_W'(1);
                if (w_cnt_reg == W_CNT_W'(1)) begin
                    w_state_next = RESP;
                end
            end
            RESP:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        r_state_next = r_state_reg;
        r_cnt_next   = r_cnt_reg;
        case (r_state_reg)
            IDLE: begin
                if (r_req) begin
                    r_cnt_next   = R_CNT_W'(READ_LATENCY - 1) + R_CNT_W'(r_extra);
                    r_state_next = (r_cnt_next == '0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                r_cnt_next = r_cnt_reg - R_CNT_W'(1);
                if (r_cnt_reg == R_CNT_W'(1)) begin
                    r_state_next = RESP;
                end
            end
            RESP:    r_state_next = IDLE;
            default: r_state_next = IDLE;
        endcase
    end

    assign w_resp     = (w_state_reg == RESP);
    assign w_err      = w_resp && w_err_reg;
    assign r_resp     = (r_state_reg == RESP);
    assign r_err      = r_resp && r_err_reg;
    assign r_data_out = r_resp ? r_hold_word : '0;

endmodule

// File: tb/tb_ram_fake_latency_mem.sv
// Directed bench for ram_fake_latency_mem: latency, byte merge, collisions, range errors, reset.
module tb_ram_fake_latency_mem;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        w_req = 1'b0;
    logic        w_ready;
    logic [31:0] w_addr = '0;
    logic [31:0] w_data_in = '0;
    logic [3:0]  w_strb = '0;
    logic        w_resp;
    logic        w_err;
    logic        r_req = 1'b0;
    logic        r_ready;
    logic [31:0] r_addr = '0;
    logic [31:0] r_data_out;
    logic        r_resp;
    logic        r_err;

    int n_cmp = 0;
    int n_bad = 0;

    ram_fake_latency_mem #(
        .WORD_W(32), .DEPTH(64), .READ_LATENCY(2), .WRITE_LATENCY(1), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .reset(reset),
        .w_req(w_req), .w_ready(w_ready), .w_addr(w_addr), .w_data_in(w_data_in),
        .w_strb(w_strb), .w_resp(w_resp), .w_err(w_err),
        .r_req(r_req), .r_ready(r_ready), .r_addr(r_addr), .r_data_out(r_data_out),
        .r_resp(r_resp), .r_err(r_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // Issues one write; lat counts negedges from accept to w_resp (-1 on timeout).
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic err, output int lat);
        int guard = 0;
        @(negedge clk);
        while (!w_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        w_req = 1'b1; w_addr = a; w_data_in = d; w_strb = s;
        @(negedge clk);
        w_req = 1'b0;
        lat = 1;
        while (!w_resp && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        err = w_err;
        if (!w_resp) lat = -1;
        $display("write addr=%0d data=%h strb=%h -> err=%0d lat=%0d", a, d, s, err, lat);
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic err,
                           output int lat);
        int guard = 0;
        @(negedge clk);
        while (!r_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        r_req = 1'b1; r_addr = a;
        @(negedge clk);
        r_req = 1'b0;
        lat = 1;
        while (!r_resp && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        d = r_data_out;
        err = r_err;
        if (!r_resp) lat = -1;
        $display("read  addr=%0d -> data=%h err=%0d lat=%0d", a, d, err, lat);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (w_ready !== 1'b1) begin n_bad++; $display("FAIL reset_w_ready: got %b want 1", w_ready); end
        n_cmp++; if (r_ready !== 1'b1) begin n_bad++; $display("FAIL reset_r_ready: got %b want 1", r_ready); end
        n_cmp++; if (w_resp !== 1'b0) begin n_bad++; $display("FAIL reset_w_resp: got %b want 0", w_resp); end
        n_cmp++; if (r_resp !== 1'b0) begin n_bad++; $display("FAIL reset_r_resp: got %b want 0", r_resp); end
        n_cmp++; if (w_err !== 1'b0 || r_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b%b want 00", w_err, r_err); end
        n_cmp++; if (r_data_out !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", r_data_out); end
        reset = 1'b0;
        $display("reset released");
    endtask

    task automatic test_read_latency();
        @(negedge clk);
        r_req = 1'b1; r_addr = 32'd5;
        @(negedge clk);
        r_req = 1'b0;
        n_cmp++; if (r_ready !== 1'b0 || r_resp !== 1'b0) begin n_bad++; $display("FAIL lat_wait: got ready=%b resp=%b want 0 0", r_ready, r_resp); end
        @(negedge clk);
        n_cmp++; if (r_resp !== 1'b1 || r_ready !== 1'b0) begin n_bad++; $display("FAIL lat_resp: got resp=%b ready=%b want 1 0", r_resp, r_ready); end
        n_cmp++; if (r_data_out !== 32'h0 || r_err !== 1'b0) begin n_bad++; $display("FAIL lat_data: got %h err=%b want 0 0", r_data_out, r_err); end
        @(negedge clk);
        n_cmp++; if (r_resp !== 1'b0 || r_ready !== 1'b1) begin n_bad++; $display("FAIL lat_idle: got resp=%b ready=%b want 0 1", r_resp, r_ready); end
        $display("read latency sequence addr=5 done");
    endtask

    task automatic test_write_merge();
        logic [31:0] d;
        logic e;
        int l;
        do_write(32'd3, 32'hDEADBEEF, 4'hF, e, l);
        n_cmp++; if (l !== 1 || e !== 1'b0) begin n_bad++; $display("FAIL wr_full: got lat=%0d err=%b want 1 0", l, e); end
        do_write(32'd3, 32'h00000011, 4'h1, e, l);
        n_cmp++; if (l !== 1) begin n_bad++; $display("FAIL wr_byte_lat: got %0d want 1", l); end
        do_read(32'd3, d, e, l);
        n_cmp++; if (d !== 32'hDEADBE11 || l !== 2) begin n_bad++; $display("FAIL rd_merge: got %h lat=%0d want deadbe11 2", d, l); end
        do_write(32'd3, 32'hFFFFFFFF, 4'h0, e, l);
        n_cmp++; if (l !== 1 || e !== 1'b0) begin n_bad++; $display("FAIL wr_nostrb: got lat=%0d err=%b want 1 0", l, e); end
        do_read(32'd3, d, e, l);
        n_cmp++; if (d !== 32'hDEADBE11) begin n_bad++; $display("FAIL rd_nostrb: got %h want deadbe11", d); end
        do_write(32'd63, 32'hAABBCCDD, 4'b0110, e, l);
        do_read(32'd63, d, e, l);
        n_cmp++; if (d !== 32'h00BBCC00 || e !== 1'b0) begin n_bad++; $display("FAIL rd_last: got %h err=%b want 00bbcc00 0", d, e); end
    endtask

    task automatic test_same_edge();
        logic [31:0] d;
        logic e;
        int l;
        @(negedge clk);
        w_req = 1'b1; w_addr = 32'd7; w_data_in = 32'h12345678; w_strb = 4'hF;
        r_req = 1'b1; r_addr = 32'd7;
        @(negedge clk);
        w_req = 1'b0; r_req = 1'b0;
        n_cmp++; if (w_resp !== 1'b1 || r_resp !== 1'b0) begin n_bad++; $display("FAIL same_wresp: got w=%b r=%b want 1 0", w_resp, r_resp); end
        @(negedge clk);
        n_cmp++; if (r_resp !== 1'b1 || r_data_out !== 32'h0) begin n_bad++; $display("FAIL same_rd_old: got resp=%b data=%h want 1 0", r_resp, r_data_out); end
        $display("same-edge write/read addr=7 rdata=%h", r_data_out);
        do_read(32'd7, d, e, l);
        n_cmp++; if (d !== 32'h12345678) begin n_bad++; $display("FAIL same_rd_new: got %h want 12345678", d); end
    endtask

    task automatic test_out_of_range();
        logic [31:0] d;
        logic e;
        int l;
        do_write(32'd64, 32'hFFFFFFFF, 4'hF, e, l);
        n_cmp++; if (e !== 1'b1 || l !== 1) begin n_bad++; $display("FAIL oor_werr: got err=%b lat=%0d want 1 1", e, l); end
        @(negedge clk);
        n_cmp++; if (w_err !== 1'b0) begin n_bad++; $display("FAIL oor_werr_clear: got %b want 0", w_err); end
        do_read(32'd100, d, e, l);
        n_cmp++; if (e !== 1'b1 || d !== 32'h0) begin n_bad++; $display("FAIL oor_rerr: got err=%b data=%h want 1 0", e, d); end
        do_read(32'd0, d, e, l);
        n_cmp++; if (e !== 1'b0 || d !== 32'h0) begin n_bad++; $display("FAIL oor_alias: got err=%b data=%h want 0 0", e, d); end
    endtask

    task automatic test_back_to_back();
        int acc[3];
        int n = 0;
        int resp_cnt = 0;
        logic prev = 1'b0;
        logic wide = 1'b0;
        acc = '{-1, -1, -1};
        @(negedge clk);
        r_req = 1'b1; r_addr = 32'd7;
        for (int c = 0; c < 15; c++) begin
            if (r_req && r_ready) begin
                if (n < 3) acc[n] = c;
                n++;
            end
            @(negedge clk);
            if (n >= 3) r_req = 1'b0;
            if (r_resp) begin
                resp_cnt++;
                if (prev) wide = 1'b1;
                prev = 1'b1;
            end else begin
                prev = 1'b0;
            end
        end
        $display("back-to-back accepts at %0d %0d %0d, resp pulses %0d", acc[0], acc[1], acc[2], resp_cnt);
        n_cmp++; if (acc[1] - acc[0] !== 3 || acc[2] - acc[1] !== 3) begin n_bad++; $display("FAIL b2b_spacing: got %0d %0d want 3 3", acc[1] - acc[0], acc[2] - acc[1]); end
        n_cmp++; if (resp_cnt !== 3) begin n_bad++; $display("FAIL b2b_resp_cnt: got %0d want 3", resp_cnt); end
        n_cmp++; if (wide !== 1'b0) begin n_bad++; $display("FAIL b2b_pulse_width: got wide=%b want 0", wide); end
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] d;
        logic e;
        int l;
        int seen = 0;
        @(negedge clk);
        r_req = 1'b1; r_addr = 32'd3;
        @(negedge clk);
        r_req = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++; if (r_ready !== 1'b1) begin n_bad++; $display("FAIL mid_reset_ready: got %b want 1", r_ready); end
        repeat (8) begin
            @(negedge clk);
            if (r_resp) seen++;
        end
        $display("mid-op reset: stray responses=%0d", seen);
        n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL mid_reset_noresp: got %0d want 0", seen); end
        do_read(32'd3, d, e, l);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL mid_reset_mem3: got %h want 0", d); end
        do_read(32'd7, d, e, l);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL mid_reset_mem7: got %h want 0", d); end
        do_read(32'd63, d, e, l);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL mid_reset_mem63: got %h want 0", d); end
    endtask

    initial begin
        test_reset();
        test_read_latency();
        test_write_merge();
        test_same_edge();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid_op();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
